// File: rtl/lsu_data_port.sv
// Load/store unit between the core execute stage and a word-only RAM data port.
// Sub-word stores are done as read-modify-write; loads are sign- or zero-extended.
module lsu_data_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    READ     = 3'd2,
    MERGE_WR = 3'd3,
    WRITE    = 3'd4,
    RESP     = 3'd5
  } state_t;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  state_t      state, state_nxt;
  logic        is_store_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] addr_out_q;
  logic [31:0] wr_word_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [1:0]  lane;
  logic        op_err;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign lane = addr_q[1:0];

  always_comb begin
    op_err = 1'b0;
    if (is_store_q)
      op_err = !(op_q == OP_B || op_q == OP_H || op_q == OP_W);
    else
      op_err = !(op_q == OP_B || op_q == OP_H || op_q == OP_W ||
                 op_q == OP_BU || op_q == OP_HU);
    if ((op_q == OP_H || op_q == OP_HU) && lane[0])
      op_err = 1'b1;
    if (op_q == OP_W && lane != 2'b00)
      op_err = 1'b1;
  end

  // Shift the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted  = data_readdata >> {lane, 3'b000};
    load_val = 32'h0;
    case (op_q)
      OP_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      OP_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      OP_W:    load_val = data_readdata;
      OP_BU:   load_val = {24'h0, shifted[7:0]};
      OP_HU:   load_val = {16'h0, shifted[15:0]};
      default: load_val = 32'h0;
    endcase
  end

  always_comb begin
    merged = data_readdata;
    if (op_q == OP_B) begin
      case (lane)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else begin
      if (lane[1])
        merged[31:16] = wdata_q[15:0];
      else
        merged[15:0]  = wdata_q[15:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req_valid) state_nxt = CHECK;
      CHECK: begin
        if (op_err)
          state_nxt = RESP;
        else if (is_store_q && op_q == OP_W)
          state_nxt = WRITE;
        else
          state_nxt = READ;
      end
      READ:     state_nxt = is_store_q ? MERGE_WR : RESP;
      MERGE_WR: state_nxt = RESP;
      WRITE:    state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      op_q       <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      addr_out_q <= 32'h0;
      wr_word_q  <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            is_store_q <= req_is_store;
            op_q       <= req_op;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
          end
        end
        CHECK: begin
          if (op_err) begin
            err_q <= 1'b1;
          end else begin
            addr_out_q <= {addr_q[31:2], 2'b00};
            if (is_store_q && op_q == OP_W)
              wr_word_q <= wdata_q;
          end
        end
        READ: begin
          if (is_store_q)
            wr_word_q <= merged;
          else
            rdata_q <= load_val;
        end
        RESP: begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == RESP);
  assign data_read      = (state == READ);
  assign data_write     = (state == MERGE_WR) || (state == WRITE);
  assign data_address   = addr_out_q;
  assign data_writedata = wr_word_q;
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// Bench for lsu_data_port: word RAM model plus a scoreboard of expected
// responses (data, error flag, completion cycle).
module tb_lsu_data_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] mem [0:15];

  always #5 clk = ~clk;

  assign data_readdata = mem[data_address[5:2]];
  always @(posedge clk) if (data_write) mem[data_address[5:2]] <= data_writedata;

  lsu_data_port dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .data_writedata(data_writedata), .data_readdata(data_readdata)
  );

  task automatic do_req(input bit st, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input bit exp_err, input int exp_cyc,
                        output logic [15:0] rd_mask, output logic [15:0] wr_mask,
                        output logic [31:0] wr_word);
    exp_t e;
    exp_t got;
    int n;
    bit done;
    rd_mask = '0;
    wr_mask = '0;
    wr_word = 32'h0;
    e.rdata = exp_rd; e.err = exp_err; e.cyc = exp_cyc;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_op = op; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL ready_wait: req_ready=%0b required 1 within 20 cycles", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_is_store = 1'($urandom); req_op = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    done = 1'b0;
    for (int k = 1; k <= 12 && !done; k++) begin
      total++;
      if (req_ready !== 1'b0) begin
        bad++;
        $display("FAIL busy_ready: cycle %0d req_ready=%0b required 0", k, req_ready);
      end
      total++;
      if (data_read && data_write) begin
        bad++;
        $display("FAIL strobe_excl: cycle %0d read and write both high", k);
      end
      if (data_read) rd_mask[k] = 1'b1;
      if (data_write) begin
        wr_mask[k] = 1'b1;
        wr_word = data_writedata;
      end
      if (data_read || data_write) begin
        total++;
        if (data_address !== {addr[31:2], 2'b00}) begin
          bad++;
          $display("FAIL data_addr: got %h required %h", data_address, {addr[31:2], 2'b00});
        end
      end
      if (resp_valid) begin
        got = sb_q.pop_front();
        done = 1'b1;
        total++;
        if (resp_rdata !== got.rdata) begin
          bad++;
          $display("FAIL resp_rdata: got %h required %h", resp_rdata, got.rdata);
        end
        total++;
        if (resp_err !== got.err) begin
          bad++;
          $display("FAIL resp_err: got %0b required %0b", resp_err, got.err);
        end
        total++;
        if (k != got.cyc) begin
          bad++;
          $display("FAIL resp_cycle: got %0d required %0d", k, got.cyc);
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      got = sb_q.pop_front();
      total++; bad++;
      $display("FAIL resp_timeout: no resp_valid in 12 cycles, required cycle %0d", got.cyc);
    end
    @(posedge clk); #1;
    total++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      bad++;
      $display("FAIL resp_clear: valid=%0b rdata=%h err=%0b required 0/0/0",
               resp_valid, resp_rdata, resp_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
        resp_rdata !== 32'h0 || data_address !== 32'h0 || data_read !== 1'b0 ||
        data_write !== 1'b0 || data_writedata !== 32'h0) begin
      bad++;
      $display("FAIL reset_vals: ready=%0b valid=%0b err=%0b rdata=%h addr=%h rd=%0b wr=%0b wd=%h",
               req_ready, resp_valid, resp_err, resp_rdata, data_address, data_read,
               data_write, data_writedata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    logic [15:0] rm, wm;
    logic [31:0] ww;
    do_req(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 3, rm, wm, ww);
    total++;
    if (rm !== 16'h0004 || wm !== 16'h0) begin
      bad++;
      $display("FAIL lb_strobes: read mask %h write mask %h required 0004/0000", rm, wm);
    end
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000088, 1'b0, 3, rm, wm, ww);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 3, rm, wm, ww);
    do_req(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 3, rm, wm, ww);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 3, rm, wm, ww);
    do_req(1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 3, rm, wm, ww);
    do_req(1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 3, rm, wm, ww);
  endtask

  task automatic test_sb();
    logic [15:0] rm, wm;
    logic [31:0] ww;
    do_req(1'b1, 3'b000, 32'h11, 32'h123456CC, 32'h0, 1'b0, 4, rm, wm, ww);
    total++;
    if (rm !== 16'h0004 || wm !== 16'h0008) begin
      bad++;
      $display("FAIL sb_strobes: read mask %h write mask %h required 0004/0008", rm, wm);
    end
    total++;
    if (ww !== 32'h8899CCBB) begin
      bad++;
      $display("FAIL sb_word: got %h required 8899CCBB", ww);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h8899CCBB, 1'b0, 3, rm, wm, ww);
  endtask

  task automatic test_sh_sw();
    logic [15:0] rm, wm;
    logic [31:0] ww;
    mem[4] = 32'h8899AABB;
    do_req(1'b1, 3'b001, 32'h12, 32'h0000BEEF, 32'h0, 1'b0, 4, rm, wm, ww);
    total++;
    if (ww !== 32'hBEEFAABB || wm !== 16'h0008) begin
      bad++;
      $display("FAIL sh_word: got %h mask %h required BEEFAABB/0008", ww, wm);
    end
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3, rm, wm, ww);
    total++;
    if (ww !== 32'hDEADBEEF || wm !== 16'h0004 || rm !== 16'h0) begin
      bad++;
      $display("FAIL sw_word: got %h wmask %h rmask %h required DEADBEEF/0004/0000", ww, wm, rm);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, rm, wm, ww);
  endtask

  task automatic test_errors();
    logic [15:0] rm, wm;
    logic [31:0] ww;
    logic        st_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  op_tab [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] ad_tab [4] = '{32'h12, 32'h11, 32'h10, 32'h10};
    for (int i = 0; i < 4; i++) begin
      do_req(st_tab[i], op_tab[i], ad_tab[i], 32'hFFFFFFFF, 32'h0, 1'b1, 2, rm, wm, ww);
      total++;
      if (rm !== 16'h0 || wm !== 16'h0) begin
        bad++;
        $display("FAIL err_strobes[%0d]: read mask %h write mask %h required 0/0", i, rm, wm);
      end
    end
    total++;
    if (mem[4] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL err_mem: got %h required DEADBEEF", mem[4]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rm, wm;
    logic [31:0] ww;
    mem[5] = 32'h7F00FF01;
    do_req(1'b0, 3'b001, 32'h16, 32'h0, 32'h00007F00, 1'b0, 3, rm, wm, ww);
    do_req(1'b0, 3'b101, 32'h14, 32'h0, 32'h0000FF01, 1'b0, 3, rm, wm, ww);
    do_req(1'b0, 3'b000, 32'h15, 32'h0, 32'hFFFFFFFF, 1'b0, 3, rm, wm, ww);
    do_req(1'b1, 3'b000, 32'h17, 32'h000000A5, 32'h0, 1'b0, 4, rm, wm, ww);
    total++;
    if (ww !== 32'hA500FF01) begin
      bad++;
      $display("FAIL b2b_sb_word: got %h required A500FF01", ww);
    end
  endtask

  task automatic test_reset_mid();
    bit seen_bad;
    mem[4] = 32'h8899AABB;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_op = 3'b000;
    req_addr = 32'h11; req_wdata = 32'h123456CC;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (data_read !== 1'b1) begin
      bad++;
      $display("FAIL mid_read: data_read=%0b required 1", data_read);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || data_read !== 1'b0 ||
        data_write !== 1'b0 || data_address !== 32'h0 || data_writedata !== 32'h0 ||
        resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_vals: ready=%0b valid=%0b rd=%0b wr=%0b addr=%h wd=%h",
               req_ready, resp_valid, data_read, data_write, data_address, data_writedata);
    end
    seen_bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (data_write || resp_valid) seen_bad = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (data_write || resp_valid) seen_bad = 1'b1;
    end
    total++;
    if (seen_bad) begin
      bad++;
      $display("FAIL mid_no_write: write or resp seen after reset, required none");
    end
    total++;
    if (req_ready !== 1'b1 || mem[4] !== 32'h8899AABB) begin
      bad++;
      $display("FAIL mid_after: ready=%0b mem=%h required 1/8899AABB", req_ready, mem[4]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899AABB;
    test_reset();
    test_loads();
    test_reset_mid();
    test_sb();
    test_sh_sw();
    test_errors();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_data_port.md
# lsu_data_port

Load/store unit that sits between the MIPS core's execute stage and the data port of the Harvard RAM. It converts byte, halfword and word load/store requests into aligned 32-bit accesses on the RAM data port, which only transfers whole words. Sub-word stores use a read-modify-write sequence. Loads are sign- or zero-extended. Misaligned or illegal requests are rejected without touching memory.

## Interface
- No parameters.
- `clk`  in  1  single clock; all state changes on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready` at posedge.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_op`  in  3  load ops: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Store ops: 000 SB, 001 SH, 010 SW. All other codes are illegal.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle pulse on completion.
- `resp_rdata`  out  32  extended load result; 0 for stores and errors.
- `resp_err`  out  1  valid with `resp_valid`; 1 = misaligned or illegal op.
- `data_address`  out  32  word-aligned address: `{req_addr[31:2], 2'b00}`.
- `data_read`  out  1  RAM read strobe.
- `data_write`  out  1  RAM write strobe.
- `data_writedata`  out  32  word written to RAM.
- `data_readdata`  in  32  combinational RAM read data for the word at `data_address`; byte k of the word is `[8k+7:8k]`.

## Operation
- On acceptance, register the op, store flag, address, wdata and lane `L = req_addr[1:0]`.
- States: IDLE, CHECK, READ, MERGE_WR, WRITE, RESP.
- Transitions:
  - IDLE → CHECK on acceptance.
  - CHECK:
    - Error → RESP with `resp_err = 1`. Error cases:
      - illegal op;
      - LH/LHU/SH with `L[0] = 1`;
      - LW/SW with `L != 0`.
    - Otherwise: loads → READ; SW → WRITE; SB/SH → READ.
  - READ drives `data_read = 1` and captures `data_readdata` at the posedge ending READ.
    - Loads → RESP.
    - SB/SH → MERGE_WR.
  - MERGE_WR drives `data_write = 1` with the captured word. Only the addressed lane(s) are replaced, using `req_wdata[7:0]` for SB and `req_wdata[15:0]` for SH. Then → RESP.
  - WRITE drives `data_write = 1` with `data_writedata = req_wdata`, then → RESP.
  - RESP: `resp_valid = 1` for one cycle, then → IDLE.
- Load extraction:
  - Byte: `word[8L+7:8L]`.
  - Half: `word[8L+15:8L]` for L ∈ {0, 2}.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- `data_read` and `data_write` are never high together.
- `data_address` holds its last value outside READ, MERGE_WR and WRITE.

## Timing
- Reset (async assert) values:
  - state IDLE;
  - `req_ready = 1`;
  - `resp_valid = 0`, `resp_err = 0`;
  - `resp_rdata = 0`;
  - `data_address = 0`;
  - `data_read = 0`, `data_write = 0`;
  - `data_writedata = 0`.
- Cycle numbering: acceptance edge closes cycle 0. Completion (`resp_valid` high) occurs in:
  - Error: cycle 2 (CHECK in 1, RESP in 2).
  - Load and SW: cycle 3.
  - SB/SH: cycle 4 (READ 2, MERGE_WR 3, RESP 4).
- Throughput: next request is accepted no earlier than the cycle after RESP. `req_ready` is 0 from cycle 1 through RESP inclusive.
- `resp_rdata`/`resp_err` are registered and stable during RESP. They clear to 0 after RESP.
- Reset mid-operation:
  - strobes drop immediately, asynchronously;
  - no write is issued after `rst_n` falls, including an SB/SH interrupted in READ;
  - no `resp_valid` for the aborted request.
- Request inputs are ignored while `req_ready = 0`.

## Test plan
- Preload word at 0x00000010 = 0x8899AABB.
- LB 0x11 → `resp_rdata` 0xFFFFFFAA, `resp_err` 0, `resp_valid` in cycle 3. LBU 0x13 → 0x00000088.
- LH 0x12 → 0xFFFF8899. LHU 0x10 → 0x0000AABB. LW 0x10 → 0x8899AABB.
- SB 0x11, wdata 0x123456CC → `data_read` high cycle 2; `data_write` high cycle 3 only, with `data_writedata` 0x8899CCBB; then LW 0x10 → 0x8899CCBB.
- SH 0x12, wdata 0x0000BEEF → write 0xBEEFAABB. SW 0x10, wdata 0xDEADBEEF → write in cycle 2; LW returns 0xDEADBEEF.
- Errors: LW 0x12, SH 0x11 and op 011 each give `resp_err = 1`, `resp_rdata = 0`, `resp_valid` in cycle 2, and `data_read`/`data_write` are never asserted.
- Pull `rst_n` low during READ of SB 0x11 → outputs return to reset values at once; memory word is unchanged at 0x8899AABB; `req_ready = 1` after release.
